aes_round_sequencer: RTL and testbench

//  Iterative AES-128 controller that sequences one shared, combinational round unit across NR rounds.

---
 rtl/aes_round_sequencer_pkg.sv | 33 +++
 rtl/aes_round_sequencer_if.sv | 38 +++
 rtl/aes_round_key_mux.sv | 25 ++
 rtl/aes_round_sequencer.sv | 121 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// rtl/aes_round_sequencer_pkg.sv - shared parameters, FSM encoding and round-key select for the AES round sequencer
package aes_round_sequencer_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int KEY_W   = (NR + 1) * BLOCK_W;
    localparam int CNT_W   = $clog2(NR + 1);

    localparam logic [CNT_W-1:0] NR_IDX = CNT_W'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    // rk[idx] lives at expanded_key[KEY_W-1-BLOCK_W*idx -: BLOCK_W]; an index past NR yields zero.
    // Written as a one-hot compare loop so it maps to a plain mux with no out-of-range slice.
    function automatic logic [BLOCK_W-1:0] rk_sel(
        input logic [KEY_W-1:0] expanded_key,
        input logic [CNT_W-1:0] idx
    );
        logic [BLOCK_W-1:0] key;
        key = '0;
        for (int r = 0; r <= NR; r++) begin
            if (idx == CNT_W'(r)) begin
                key = expanded_key[KEY_W-1-BLOCK_W*r -: BLOCK_W];
            end
        end
        return key;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// rtl/aes_round_sequencer_if.sv - block source/sink handshake bundle for the AES round sequencer
interface aes_round_sequencer_if;

    logic                                         in_valid;
    logic                                         in_ready;
    logic [aes_round_sequencer_pkg::BLOCK_W-1:0]  in_block;
    logic                                         in_decrypt;

    logic                                         out_valid;
    logic                                         out_ready;
    logic [aes_round_sequencer_pkg::BLOCK_W-1:0]  out_block;
    logic                                         out_decrypt;

    // Environment side: block source plus block sink.
    modport master (
        output in_valid,
        output in_block,
        output in_decrypt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_block,
        input  out_decrypt
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  in_block,
        input  in_decrypt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_block,
        output out_decrypt
    );

endinterface

// File: rtl/aes_round_key_mux.sv
// rtl/aes_round_key_mux.sv - selects the per-round key and the initial whitening key from the expanded key
module aes_round_key_mux
    import aes_round_sequencer_pkg::*;
(
    input  logic [KEY_W-1:0]   expanded_key,
    input  logic               round_active,
    input  logic [CNT_W-1:0]   round_idx,
    input  logic               round_decrypt,
    input  logic               init_decrypt,
    output logic [BLOCK_W-1:0] round_key,
    output logic [BLOCK_W-1:0] init_key
);

    logic [CNT_W-1:0] round_sel;
    logic [CNT_W-1:0] init_sel;

    // Decrypt walks the schedule backwards: round r uses rk[NR-r] and whitening uses rk[NR].
    always_comb begin
        round_sel = round_decrypt ? (NR_IDX - round_idx) : round_idx;
        init_sel  = init_decrypt ? NR_IDX : '0;
        round_key = round_active ? rk_sel(expanded_key, round_sel) : '0;
        init_key  = rk_sel(expanded_key, init_sel);
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 controller driving one shared combinational round unit
module aes_round_sequencer
    import aes_round_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_W-1:0]     expanded_key,
    input  logic                 key_valid,
    aes_round_sequencer_if.slave blk,
    output logic [BLOCK_W-1:0]   rnd_state,
    output logic [BLOCK_W-1:0]   rnd_key,
    output logic                 rnd_last,
    output logic                 rnd_decrypt,
    input  logic [BLOCK_W-1:0]   rnd_result,
    output logic                 busy,
    output logic                 aborted
);

    seq_state_e         fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               mode_q, mode_d;
    logic               aborted_q, aborted_d;

    logic               in_ready_int;
    logic               accept;
    logic               round_active;
    logic [BLOCK_W-1:0] init_key;
    logic [BLOCK_W-1:0] round_key;

    assign round_active = (fsm_q == ROUND);
    assign in_ready_int = (fsm_q == IDLE) && key_valid;
    assign accept       = blk.in_valid && in_ready_int;

    aes_round_key_mux u_key_mux (
        .expanded_key  (expanded_key),
        .round_active  (round_active),
        .round_idx     (cnt_q),
        .round_decrypt (mode_q),
        .init_decrypt  (blk.in_decrypt),
        .round_key     (round_key),
        .init_key      (init_key)
    );

    // Next-state logic: accept and whiten in IDLE, iterate rounds, hold the result until the sink takes it.
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        mode_d    = mode_q;
        aborted_d = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (accept) begin
                    data_d = blk.in_block ^ init_key;
                    mode_d = blk.in_decrypt;
                    cnt_d  = CNT_W'(1);
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                if (!key_valid) begin
                    // Round keys are no longer trustworthy: drop the block without producing output.
                    fsm_d     = IDLE;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else begin
                    data_d = rnd_result;
                    if (cnt_q == NR_IDX) begin
                        fsm_d = DONE;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (blk.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            aborted_q <= aborted_d;
        end
    end

    // Output decode from the registered state; the block output is only exposed in DONE.
    always_comb begin
        blk.in_ready    = in_ready_int;
        blk.out_valid   = (fsm_q == DONE);
        blk.out_block   = (fsm_q == DONE) ? data_q : '0;
        blk.out_decrypt = (fsm_q == DONE) && mode_q;
        rnd_state       = data_q;
        rnd_key         = round_key;
        rnd_last        = round_active && (cnt_q == NR_IDX);
        rnd_decrypt     = mode_q;
        busy            = (fsm_q != IDLE);
        aborted         = aborted_q;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer with a behavioural AES round unit
module tb_aes_round_sequencer;
    import aes_round_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               key_valid;
    logic [KEY_W-1:0]   ek;
    logic [BLOCK_W-1:0] rnd_state;
    logic [BLOCK_W-1:0] rnd_key;
    logic [BLOCK_W-1:0] rnd_result;
    logic               rnd_last;
    logic               rnd_decrypt;
    logic               busy;
    logic               aborted;

    aes_round_sequencer_if bus();

    aes_round_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .expanded_key (ek),
        .key_valid    (key_valid),
        .blk          (bus),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_last     (rnd_last),
        .rnd_decrypt  (rnd_decrypt),
        .rnd_result   (rnd_result),
        .busy         (busy),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    logic [7:0] sbox [256];
    logic [7:0] inv_sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
                ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
            sbox[a]     = s;
            inv_sbox[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv ? inv_sbox[x[127-8*i -: 8]] : sbox[x[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
        logic [127:0] o;
        int src;
        int dst;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = r + 4 * ((c + r) % 4);
                dst = r + 4 * c;
                if (!inv) o[127-8*dst -: 8] = x[127-8*src -: 8];
                else      o[127-8*src -: 8] = x[127-8*dst -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            if (!inv) begin
                o[127-32*c -: 32] = {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
                                     a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
                                     a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
                                     gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
            end else begin
                o[127-32*c -: 32] = {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
                                     gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
                                     gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
                                     gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14)};
            end
        end
        return o;
    endfunction

    function automatic logic [KEY_W-1:0] expand_key(input logic [127:0] key);
        logic [31:0]      w [44];
        logic [31:0]      t;
        logic [7:0]       rcon;
        logic [KEY_W-1:0] e;
        rcon = 8'h01;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                w[i] = key[127-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                    t[31:24] = t[31:24] ^ rcon;
                    rcon = xtime(rcon);
                end
                w[i] = w[i-4] ^ t;
            end
            e[KEY_W-1-32*i -: 32] = w[i];
        end
        return e;
    endfunction

    function automatic logic [127:0] rk(input logic [KEY_W-1:0] e, input int r);
        return e[KEY_W-1-128*r -: 128];
    endfunction

    // Whole-block FIPS-197 cipher used as the expected-value reference.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [KEY_W-1:0] e);
        logic [127:0] s;
        s = pt ^ rk(e, 0);
        for (int r = 1; r <= NR; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < NR) s = mix_columns(s, 1'b0);
            s = s ^ rk(e, r);
        end
        return s;
    endfunction

    // External round unit: one forward or inverse round, MixColumns skipped on the last round.
    function automatic logic [127:0] round_unit(input logic [127:0] st, input logic [127:0] key,
                                                 input logic last, input logic dec);
        logic [127:0] t;
        if (!dec) begin
            t = shift_rows(sub_bytes(st, 1'b0), 1'b0);
            if (!last) t = mix_columns(t, 1'b0);
            t = t ^ key;
        end else begin
            t = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ key;
            if (!last) t = mix_columns(t, 1'b1);
        end
        return t;
    endfunction

    assign rnd_result = round_unit(rnd_state, rnd_key, rnd_last, rnd_decrypt);

    // ---------------- output / event monitor ----------------
    logic [127:0] out_blk_q [$];
    logic         out_dec_q [$];
    int           abort_cnt = 0;
    int           ov_cnt    = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                out_blk_q.push_back(bus.out_block);
                out_dec_q.push_back(bus.out_decrypt);
            end
            if (aborted)       abort_cnt++;
            if (bus.out_valid) ov_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    // Called in a drive slot (just after a rising edge); returns in the drive slot after the accepting edge.
    task automatic send_block(input logic [127:0] blk, input logic dec, input logic hold, output int acc);
        bus.in_valid   = 1'b1;
        bus.in_block   = blk;
        bus.in_decrypt = dec;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_output(input string tag, input int acc, input logic [127:0] exp_blk, input logic exp_dec);
        int d;
        bit found;
        found = 0;
        d = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = cyc - acc;
            if (bus.out_valid) begin
                found = 1;
                break;
            end
            if (d >= 1 && d <= NR) begin
                check({tag, "_rnd_key"}, rnd_key, rk(ek, exp_dec ? NR - d : d));
                check({tag, "_rnd_last"}, 128'(rnd_last), 128'(d == NR));
                check({tag, "_rnd_dec"}, 128'(rnd_decrypt), 128'(exp_dec));
                check({tag, "_busy"}, 128'(busy), 128'd1);
                if (d == 1) check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
            end
        end
        if (!found) begin
            check({tag, "_out_timeout"}, 128'd0, 128'd1);
        end else begin
            check({tag, "_latency"}, 128'(d), 128'(NR + 1));
            check({tag, "_out_block"}, bus.out_block, exp_blk);
            check({tag, "_out_dec"}, 128'(bus.out_decrypt), 128'(exp_dec));
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int           acc;
        int           accs [3];
        int           n0;
        int           ab0;
        int           ov0;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] exp_b [3];
        logic         exp_d [3];
        logic [127:0] blk;
        logic         dec;

        build_sbox();
        rst            = 1'b1;
        key_valid      = 1'b0;
        ek             = expand_key(128'h000102030405060708090a0b0c0d0e0f);
        bus.in_valid   = 1'b0;
        bus.in_block   = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_block", bus.out_block, 128'd0);
        check("rst_out_dec", 128'(bus.out_decrypt), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_aborted", 128'(aborted), 128'd0);
        check("rst_rnd_key", rnd_key, 128'd0);
        check("rst_rnd_last", 128'(rnd_last), 128'd0);
        check("rst_rnd_dec", 128'(rnd_decrypt), 128'd0);
        check("rst_rnd_state", rnd_state, 128'd0);

        @(posedge clk); #1;
        rst           = 1'b0;
        key_valid     = 1'b1;
        bus.out_ready = 1'b1;

        // 1: FIPS-197 C.1 encrypt
        send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, acc);
        wait_output("enc_fips", acc, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);

        // 2: decrypt the same ciphertext
        @(posedge clk); #1;
        send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1'b0, acc);
        wait_output("dec_fips", acc, 128'h00112233445566778899aabbccddeeff, 1'b1);

        // new random key loaded while idle
        @(posedge clk); #1;
        key_valid = 1'b0;
        ek        = expand_key(rand128());
        @(posedge clk); #1;
        key_valid = 1'b1;

        // 3: sink stalls for 5 cycles in DONE
        bus.out_ready = 1'b0;
        pt = rand128();
        send_block(pt, 1'b0, 1'b0, acc);
        ct = ref_encrypt(pt, ek);
        wait_output("stall", acc, ct, 1'b0);
        n0 = out_blk_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 128'(bus.out_valid), 128'd1);
            check("stall_out_block", bus.out_block, ct);
            check("stall_in_ready", 128'(bus.in_ready), 128'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_after_valid", 128'(bus.out_valid), 128'd0);
        check("stall_xfer_count", 128'(out_blk_q.size()), 128'(n0 + 1));
        if (out_blk_q.size() > 0) check("stall_xfer_block", out_blk_q[$], ct);

        // 4: in_valid with key_valid low in IDLE
        @(posedge clk); #1;
        key_valid      = 1'b0;
        pt             = rand128();
        bus.in_valid   = 1'b1;
        bus.in_block   = pt;
        bus.in_decrypt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nokey_in_ready", 128'(bus.in_ready), 128'd0);
            check("nokey_busy", 128'(busy), 128'd0);
        end
        @(posedge clk); #1;
        key_valid = 1'b1;
        @(negedge clk);
        check("key_up_in_ready", 128'(bus.in_ready), 128'd1);
        acc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_output("key_up", acc, ref_encrypt(pt, ek), 1'b0);

        // 5: key_valid drops during round 4
        @(posedge clk); #1;
        send_block(rand128(), 1'b0, 1'b0, acc);
        for (int i = 0; i < 10 && (cyc - acc) < 4; i++) begin
            @(posedge clk); #1;
        end
        ab0 = abort_cnt;
        ov0 = ov_cnt;
        key_valid = 1'b0;
        @(negedge clk);
        check("abort_pre_busy", 128'(busy), 128'd1);
        check("abort_pre_pulse", 128'(aborted), 128'd0);
        @(negedge clk);
        check("abort_pulse", 128'(aborted), 128'd1);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;
        key_valid = 1'b1;
        @(negedge clk);
        check("abort_pulse_end", 128'(aborted), 128'd0);
        repeat (12) @(negedge clk);
        check("abort_count", 128'(abort_cnt), 128'(ab0 + 1));
        check("abort_no_output", 128'(ov_cnt), 128'(ov0));

        @(posedge clk); #1;
        pt = rand128();
        send_block(ref_encrypt(pt, ek), 1'b1, 1'b0, acc);
        wait_output("post_abort", acc, pt, 1'b1);

        // 6: three blocks back to back
        @(posedge clk); #1;
        n0 = out_blk_q.size();
        for (int i = 0; i < 3; i++) begin
            dec = 1'($urandom % 2);
            if (dec) begin
                pt  = rand128();
                blk = ref_encrypt(pt, ek);
                exp_b[i] = pt;
            end else begin
                blk = rand128();
                exp_b[i] = ref_encrypt(blk, ek);
            end
            exp_d[i] = dec;
            send_block(blk, dec, (i < 2), accs[i]);
        end
        for (int i = 0; i < 60 && out_blk_q.size() < n0 + 3; i++) @(negedge clk);
        check("b2b_count", 128'(out_blk_q.size()), 128'(n0 + 3));
        check("b2b_gap01", 128'(accs[1] - accs[0]), 128'(NR + 2));
        check("b2b_gap12", 128'(accs[2] - accs[1]), 128'(NR + 2));
        for (int i = 0; i < 3; i++) begin
            if (out_blk_q.size() > n0 + i) begin
                check("b2b_block", out_blk_q[n0 + i], exp_b[i]);
                check("b2b_dec", 128'(out_dec_q[n0 + i]), 128'(exp_d[i]));
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
